// File: rtl/controlador_execucao_pkg.sv
// Shared definitions for the run sequencer: state encoding and default timing
// constants, also used by the board-level wrapper.
package controlador_execucao_pkg;

  typedef logic [2:0] estado_t;

  localparam estado_t OCIOSO    = 3'd0;
  localparam estado_t EMITE     = 3'd1;
  localparam estado_t INTERVALO = 3'd2;
  localparam estado_t PARADO    = 3'd3;
  localparam estado_t ERRO      = 3'd4;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned WATCHDOG_CYCLES_DEF = 16;
  localparam int unsigned GAP_CYCLES_DEF      = 1;

  // A zero limit means unlimited; otherwise only an exact match stops the run.
  function automatic logic atinge_limite(input logic [15:0] cont, input logic [15:0] lim);
    return (lim != '0) && (cont == lim);
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Push-button conditioner: two-flop synchroniser, debounce counter and a
// one-cycle pulse on each debounced press (1->0 of the active-low key).
module debounce_botao
  import controlador_execucao_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_pressao
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_estavel;
  logic          r_pressao;
  logic [CW-1:0] r_cnt;

  // The counter tracks consecutive samples that differ from the debounced level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_estavel <= 1'b1;
      r_pressao <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_key_n;
      r_sync2   <= r_sync1;
      r_pressao <= 1'b0;
      if (r_sync2 == r_estavel) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt     <= '0;
        r_estavel <= r_sync2;
        r_pressao <= r_estavel;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pressao = r_pressao;

endmodule

// File: rtl/controlador_execucao.sv
// Run sequencer for processador_multiciclo: converts key presses into Run/Done
// handshakes in step or continuous mode, with instruction limit and watchdog.
module controlador_execucao
  import controlador_execucao_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES      = GAP_CYCLES_DEF
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Key_step,
  input  logic        Modo_continuo,
  input  logic        Parar,
  input  logic [15:0] Limite,
  input  logic        Done,
  output logic        Run,
  output logic        Ocupado,
  output logic        Parado,
  output logic        Erro,
  output logic [15:0] Contador
);

  localparam int unsigned WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  estado_t       r_estado;
  estado_t       w_prox;
  logic          r_modo;
  logic          r_parar;
  logic [WW-1:0] r_wd;
  logic [GW-1:0] r_gap;
  logic [15:0]   r_contador;
  logic [15:0]   w_cont_inc;
  logic          w_aceita_done;
  logic          w_pressao;
  logic          r_run;
  logic          r_ocupado;
  logic          r_parado;
  logic          r_erro;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk    (Clock),
    .i_rst_n  (Resetn),
    .i_key_n  (Key_step),
    .o_pressao(w_pressao)
  );

  always_comb begin
    w_prox        = r_estado;
    w_aceita_done = 1'b0;
    w_cont_inc    = r_contador + 16'd1;
    case (r_estado)
      OCIOSO: begin
        if (w_pressao) w_prox = EMITE;
      end
      EMITE: begin
        if (Done) begin
          w_aceita_done = 1'b1;
          if (!r_modo)
            w_prox = OCIOSO;
          else if (atinge_limite(w_cont_inc, Limite) || Parar || r_parar)
            w_prox = PARADO;
          else
            w_prox = INTERVALO;
        end else if (r_wd == WW'(WATCHDOG_CYCLES - 1)) begin
          w_prox = ERRO;
        end
      end
      INTERVALO: begin
        if (Parar || r_parar)
          w_prox = PARADO;
        else if (r_gap == GW'(GAP_CYCLES - 1))
          w_prox = EMITE;
      end
      PARADO: begin
        if (w_pressao) w_prox = OCIOSO;
      end
      ERRO: begin
        w_prox = ERRO;
      end
      default: begin
        w_prox = OCIOSO;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with r_estado.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_estado   <= OCIOSO;
      r_modo     <= 1'b0;
      r_parar    <= 1'b0;
      r_wd       <= '0;
      r_gap      <= '0;
      r_contador <= '0;
      r_run      <= 1'b0;
      r_ocupado  <= 1'b0;
      r_parado   <= 1'b0;
      r_erro     <= 1'b0;
    end else begin
      r_estado  <= w_prox;
      r_run     <= (w_prox == EMITE);
      r_ocupado <= (w_prox == EMITE) || (w_prox == INTERVALO);
      r_parado  <= (w_prox == PARADO);
      r_erro    <= (w_prox == ERRO);

      if ((r_estado == OCIOSO) && w_pressao) r_modo <= Modo_continuo;
      if (w_aceita_done) r_contador <= w_cont_inc;

      r_wd  <= ((r_estado == EMITE) && (w_prox == EMITE)) ? r_wd + 1'b1 : '0;
      r_gap <= ((r_estado == INTERVALO) && (w_prox == INTERVALO)) ? r_gap + 1'b1 : '0;

      // A stop request is held until the next instruction boundary.
      if (w_prox == OCIOSO)
        r_parar <= 1'b0;
      else if (Parar && ((r_estado == EMITE) || (r_estado == INTERVALO)))
        r_parar <= 1'b1;
    end
  end

  assign Run      = r_run;
  assign Ocupado  = r_ocupado;
  assign Parado   = r_parado;
  assign Erro     = r_erro;
  assign Contador = r_contador;

endmodule

// File: doc/controlador_execucao.md
Name: controlador_execucao

Overview:
- Upstream run sequencer for processador_multiciclo; it drives Run and consumes Done.
- Turns a board push-button and switches into per-instruction Run handshakes.
- Supports single-step and continuous modes, an instruction limit and a stall watchdog.
- Exposes a busy/halted/error status and its own completed-instruction count for the display logic.

Parameters:
- DEBOUNCE_CYCLES, 4, stable cycles required on the synchronised key before a press is accepted (board build overrides to 500000).
- WATCHDOG_CYCLES, 16, maximum cycles Run may stay high without Done before entering ERRO.
- GAP_CYCLES, 1, idle cycles with Run low between consecutive instructions in continuous mode (>=1).

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous active-low reset.
- Key_step  input  1  raw push-button, active-low, asynchronous to Clock.
- Modo_continuo  input  1  switch: 0 = step mode, 1 = continuous mode; sampled only in OCIOSO.
- Parar  input  1  synchronous request to stop continuous execution.
- Limite  input  16  instruction limit for continuous mode; 0 means unlimited.
- Done  input  1  processor instruction-complete pulse.
- Run  output  1  held high to the processor while an instruction executes.
- Ocupado  output  1  high in states EMITE and INTERVALO.
- Parado  output  1  high in state PARADO.
- Erro  output  1  high in state ERRO (sticky).
- Contador  output  16  number of Done pulses accepted while in EMITE.

Behaviour:
- Reset (async, Resetn=0):
  - state = OCIOSO.
  - Run, Ocupado, Parado and Erro = 0; Contador = 0.
  - Synchroniser flops = 1; debounce counter = 0; watchdog counter = 0.
- Key path:
  - Two-flop synchroniser, then the debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A press is a debounced 1->0 transition and produces a one-cycle pressao pulse.
  - Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- OCIOSO:
  - On pressao: go to EMITE; Run=1 from the next cycle.
  - Latch Modo_continuo into the internal mode bit at this point.
- EMITE:
  - Run=1; the watchdog increments every cycle.
  - Done=1: increment Contador (wraps 0xFFFF->0); Run drops the next cycle; watchdog clears.
  - Next state after Done:
    - Step mode: OCIOSO.
    - Continuous mode, Limite!=0 and the new Contador == Limite: PARADO.
    - Continuous mode, Parar=1 in the same cycle as Done: PARADO.
    - Otherwise: INTERVALO.
  - Watchdog reaches WATCHDOG_CYCLES with no Done: go to ERRO; Run=0.
  - Parar alone does not abort an instruction in flight; it is registered and honoured at the next Done.
- INTERVALO:
  - Run=0 for GAP_CYCLES cycles, then EMITE.
  - Parar (live or registered) during INTERVALO: PARADO instead of EMITE.
- PARADO:
  - Parado=1.
  - pressao: clear the registered Parar and return to OCIOSO; Contador is retained.
- ERRO:
  - Erro=1; Run=0; key presses are ignored.
  - Exit only via Resetn.
- Done outside EMITE is ignored: no count, no state change.
- Presses in EMITE, INTERVALO or ERRO are discarded, not queued.
- Contador == Limite exactly is the stop condition. If Limite is already below Contador at start, execution continues until wrap-around reaches Limite.
- Resetn asserted mid-instruction: Run drops asynchronously; the processor is reset by the same signal.
- All outputs are registered; Run changes only on a Clock edge except under reset.

Decomposition:
- Shared package holds:
  - the state encoding (OCIOSO=0, EMITE=1, INTERVALO=2, PARADO=3, ERRO=4; 3 bits);
  - the default DEBOUNCE/WATCHDOG constants, reused by the top-level board wrapper.
- One natural sub-module, debounce_botao: synchroniser, debounce counter and falling-edge pulse generator. It is parameterised by DEBOUNCE_CYCLES and reusable for the board's other keys.

Test Plan:
- Step mode:
  - Stimulus: Modo_continuo=0; hold Key_step low for 6 cycles; Done pulses 3 cycles after Run rises.
  - Required: Run high for exactly 3 cycles, back to OCIOSO, Contador=1, no second Run without a new press.
- Bounce rejection:
  - Stimulus: toggle Key_step with 2-cycle pulses 5 times, then hold low for 6 cycles.
  - Required: exactly one EMITE entry, Contador=1.
- Continuous mode with limit:
  - Stimulus: Modo_continuo=1, Limite=4, press; Done pulses 2 cycles after each Run rise.
  - Required: 4 Run episodes separated by 1 low cycle; Parado=1; Contador=4.
- Parar mid-instruction:
  - Stimulus: continuous mode, Limite=0; pulse Parar while in EMITE during the 2nd instruction.
  - Required: the 2nd instruction completes (Contador=2), then PARADO, and no 3rd Run.
- Watchdog:
  - Stimulus: press in step mode, never assert Done.
  - Required: Erro=1 and Run=0 after 16 cycles of Run; further presses are ignored.
- Reset and wrap:
  - Stimulus: assert Resetn low mid-EMITE.
  - Required: Run=0 immediately (no Clock edge) and all outputs return to their reset values.
  - Stimulus: preload 0xFFFF completions (force), then complete 1 more instruction.
  - Required: Contador=0x0000.
